// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement and report sign.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          sh_q, sh_d;
    logic [4*DIGITS-1:0]       dig_q, dig_d;
    logic [4*DIGITS-1:0]       bcd_q, bcd_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic [4*DIGITS-1:0]       corr;
    logic [4*DIGITS+WIDTH-1:0] shifted;
    logic [WIDTH-1:0]          load_val;

`ifdef BIN2BCD_SIGNED_EN
    logic sign_q, sign_d;
    logic pend_q, pend_d;

    // Most-negative input negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
    assign load_val = bin[WIDTH-1] ? ((~bin) + {{(WIDTH-1){1'b0}}, 1'b1}) : bin;
    assign sign     = sign_q;
`else
    assign load_val = bin;
    assign sign     = 1'b0;
`endif

    always_comb begin
        corr = dig_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (dig_q[4*i +: 4] >= 4'd5)
                corr[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
        end
        shifted = {corr, sh_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        dig_d   = dig_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
        sign_d  = sign_q;
        pend_d  = pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = load_val;
                    dig_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = SHIFT;
`ifdef BIN2BCD_SIGNED_EN
                    pend_d  = bin[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                dig_d = shifted[4*DIGITS+WIDTH-1:WIDTH];
                sh_d  = shifted[WIDTH-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = shifted[4*DIGITS+WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef BIN2BCD_SIGNED_EN
                    sign_d  = pend_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            dig_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            sign_q  <= 1'b0;
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            dig_q   <= dig_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef BIN2BCD_SIGNED_EN
            sign_q  <= sign_d;
            pend_q  <= pend_d;
`endif
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq at WIDTH=8, DIGITS=3; signed vectors run only
// when BIN2BCD_SIGNED_EN is defined.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic        sign;

    int n_checks = 0;
    int n_errors = 0;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .sign  (sign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge. Sample s is taken after edge T0+s;
    // busy is expected for s=0..7 and done at s=8. With poke set, a second
    // start (bin=45) is driven mid-conversion and must be ignored.
    task automatic do_conv(input logic [7:0] b, input logic [11:0] exp_bcd,
                           input logic exp_sign, input bit hold_start, input bit poke);
        bin   = b;
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        for (int s = 0; s <= 8; s++) begin
            if (poke && s == 2) begin
                start = 1'b1;
                bin   = 8'd45;
            end
            if (poke && s == 4) start = 1'b0;
            check("busy", 32'(busy), 32'(s < 8));
            check("done", 32'(done), 32'(s == 8));
            if (s == 8) begin
                check("bcd",  32'(bcd),  32'(exp_bcd));
                check("sign", 32'(sign), 32'(exp_sign));
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd",  32'(bcd),  32'h000);
        check("rst_sign", 32'(sign), 32'd0);
        tick();

        do_conv(8'd0,   12'h000, 1'b0, 1'b0, 1'b0);
        tick();
        do_conv(8'd255, 12'h255, 1'b0, 1'b0, 1'b0);
        do_conv(8'd9,   12'h009, 1'b0, 1'b0, 1'b0);
        do_conv(8'd10,  12'h010, 1'b0, 1'b0, 1'b0);
        do_conv(8'd99,  12'h099, 1'b0, 1'b0, 1'b0);
        tick();

        // Start while busy is ignored; result then holds with start low.
        do_conv(8'd123, 12'h123, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_bcd",  32'(bcd),  32'h123);
            check("hold_done", 32'(done), 32'd0);
            check("hold_busy", 32'(busy), 32'd0);
        end

        // Back-to-back with start held high, bin alternating.
        tick();
        do_conv(8'd200, 12'h200, 1'b0, 1'b1, 1'b0);
        do_conv(8'd7,   12'h007, 1'b0, 1'b1, 1'b0);
        do_conv(8'd200, 12'h200, 1'b0, 1'b1, 1'b0);
        do_conv(8'd7,   12'h007, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset mid-conversion: edge T4 applies reset.
        bin   = 8'd77;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd",  32'(bcd),  32'h000);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end
        do_conv(8'd58, 12'h058, 1'b0, 1'b0, 1'b0);
        tick();

`ifdef BIN2BCD_SIGNED_EN
        do_conv(8'h80, 12'h128, 1'b1, 1'b0, 1'b0);
        do_conv(8'hFF, 12'h001, 1'b1, 1'b0, 1'b0);
        do_conv(8'h7F, 12'h127, 1'b0, 1'b0, 1'b0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
